// File: rtl/spi_hs_pkg.sv
// Shared widths, FSM state encoding and the abort response value for the
// two-requester SPI master handshake arbiter.
package spi_hs_pkg;

    localparam int HS_ADDR_W = 5;
    localparam int HS_DATA_W = 8;

    // Read data returned to a requester whose transfer was aborted
    localparam logic [HS_DATA_W-1:0] TIMEOUT_DATA = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/hs_timeout_cnt.sv
// Stall watchdog for a forwarded handshake beat. Present only when
// SPI_HS_ARB_TIMEOUT_EN is defined; the default build has no such module.
// The count runs while a strobe is forwarded and is zero whenever it is not,
// so every new forwarded beat starts from zero.
`ifdef SPI_HS_ARB_TIMEOUT_EN
module hs_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic clr_i,
    output logic hit_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count forwarded cycles; restart on completion or when nothing is forwarded
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i || !run_i) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign hit_o = run_i && (r_cnt == LAST);

endmodule
`endif

// File: rtl/spi_hs_arb.sv
// Two-requester round-robin arbiter in front of the SPI master handshake
// port. The granted requester's strobes, address and write data pass through
// combinationally; completion and read data return combinationally.
// Optional stall abort: define SPI_HS_ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no owner; pick a requester (tie goes to the one not in rr_last)
// GNT0    | requester 0 owns the handshake port (held across beats by lock)
// GNT1    | requester 1 owns the handshake port (held across beats by lock)
module spi_hs_arb
    import spi_hs_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req0_read_i,
    input  logic                 req0_write_i,
    input  logic [HS_ADDR_W-1:0] req0_addr_i,
    input  logic [HS_DATA_W-1:0] req0_data_i,
    input  logic                 req0_lock_i,
    output logic                 req0_ready_o,
    output logic [HS_DATA_W-1:0] req0_data_o,
    input  logic                 req1_read_i,
    input  logic                 req1_write_i,
    input  logic [HS_ADDR_W-1:0] req1_addr_i,
    input  logic [HS_DATA_W-1:0] req1_data_i,
    input  logic                 req1_lock_i,
    output logic                 req1_ready_o,
    output logic [HS_DATA_W-1:0] req1_data_o,
    output logic                 hs_read_o,
    output logic                 hs_write_o,
    output logic [HS_ADDR_W-1:0] hs_addr_o,
    output logic [HS_DATA_W-1:0] hs_data_o,
    input  logic                 hs_ready_i,
    input  logic [HS_DATA_W-1:0] hs_data_i,
    output logic                 arb_err_o
);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic                 r_rr_last;

    logic                 w_act0;
    logic                 w_act1;
    logic                 w_fwd0;
    logic                 w_fwd1;
    logic                 w_fwd;
    logic                 w_done;
    logic                 w_expire;
    logic                 w_hs_en;
    logic                 w_ready;
    logic [HS_DATA_W-1:0] w_rsp_data;

    assign w_act0 = req0_read_i | req0_write_i;
    assign w_act1 = req1_read_i | req1_write_i;

    // Reset masks the grant so every output is quiet while rst_i is high
    assign w_fwd0 = !rst_i && (r_state == ST_GNT0) && w_act0;
    assign w_fwd1 = !rst_i && (r_state == ST_GNT1) && w_act1;
    assign w_fwd  = w_fwd0 | w_fwd1;
    assign w_done = w_fwd & hs_ready_i;

`ifdef SPI_HS_ARB_TIMEOUT_EN
    logic w_hit;
    logic r_err;

    hs_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .run_i (w_fwd),
        .clr_i (w_done),
        .hit_o (w_hit)
    );

    // A late hs_ready_i in the expiry cycle still counts as a real completion
    assign w_expire = w_hit & ~hs_ready_i;

    // Sticky abort flag, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_expire) begin
            r_err <= 1'b1;
        end
    end

    assign arb_err_o = r_err;
`else
    assign w_expire  = 1'b0;
    assign arb_err_o = 1'b0;
`endif

    assign w_hs_en    = w_fwd & ~w_expire;
    assign w_ready    = w_done | w_expire;
    assign w_rsp_data = w_done ? hs_data_i : TIMEOUT_DATA;

    // Forward the owner's request to the SPI master; write wins over read
    always_comb begin
        hs_read_o  = 1'b0;
        hs_write_o = 1'b0;
        hs_addr_o  = '0;
        hs_data_o  = '0;
        if (w_hs_en) begin
            if (w_fwd0) begin
                hs_write_o = req0_write_i;
                hs_read_o  = req0_read_i & ~req0_write_i;
                hs_addr_o  = req0_addr_i;
                hs_data_o  = req0_data_i;
            end else begin
                hs_write_o = req1_write_i;
                hs_read_o  = req1_read_i & ~req1_write_i;
                hs_addr_o  = req1_addr_i;
                hs_data_o  = req1_data_i;
            end
        end
    end

    // Route completion and read data back to the owner only
    always_comb begin
        req0_ready_o = w_ready & w_fwd0;
        req1_ready_o = w_ready & w_fwd1;
        req0_data_o  = (w_ready & w_fwd0) ? w_rsp_data : '0;
        req1_data_o  = (w_ready & w_fwd1) ? w_rsp_data : '0;
    end

    // Grant selection, lock hold and release
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_act0 && w_act1) begin
                    w_state_nxt = r_rr_last ? ST_GNT0 : ST_GNT1;
                end else if (w_act0) begin
                    w_state_nxt = ST_GNT0;
                end else if (w_act1) begin
                    w_state_nxt = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (w_expire) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_done) begin
                    w_state_nxt = req0_lock_i ? ST_GNT0 : ST_IDLE;
                end else if (!w_act0 && !req0_lock_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (w_expire) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_done) begin
                    w_state_nxt = req1_lock_i ? ST_GNT1 : ST_IDLE;
                end else if (!w_act1 && !req1_lock_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; rr_last follows whichever requester is granted
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_rr_last <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == ST_GNT0) begin
                r_rr_last <= 1'b0;
            end else if (w_state_nxt == ST_GNT1) begin
                r_rr_last <= 1'b1;
            end
        end
    end

endmodule
